// File: rtl/db_format_bank.sv
// Multi-channel double-buffered pin formatter: one shared cycle counter, a small
// timing-set file, five drive formats, and underrun/overrun reporting.
module db_format_bank #(
    parameter int CH  = 8,
    parameter int EW  = 7,
    parameter int LW  = 8,
    parameter int NTS = 2,
    localparam int AW = (NTS > 1) ? $clog2(NTS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            load_i,
    input  logic [CH-1:0]   d_i,
    input  logic [3*CH-1:0] fmt_i,
    input  logic [AW-1:0]   tset_sel_i,
    input  logic            tset_wr_i,
    input  logic [AW-1:0]   tset_addr_i,
    input  logic [EW-1:0]   tset_le_i,
    input  logic [EW-1:0]   tset_te_i,
    input  logic [LW-1:0]   tset_len_i,
    input  logic            clr_flags_i,
    output logic [CH-1:0]   q_o,
    output logic            ready_o,
    output logic            cycle_start_o,
    output logic            underrun_o,
    output logic            overrun_o
);

    localparam int CW = (EW > LW) ? EW : LW;

    localparam logic [2:0] FMT_NRZ  = 3'b000;
    localparam logic [2:0] FMT_DNRZ = 3'b001;
    localparam logic [2:0] FMT_RZ   = 3'b010;
    localparam logic [2:0] FMT_R1   = 3'b011;
    localparam logic [2:0] FMT_SBC  = 3'b100;

    logic [EW-1:0]   ts_le_q  [NTS];
    logic [EW-1:0]   ts_te_q  [NTS];
    logic [LW-1:0]   ts_len_q [NTS];

    logic            stg_full_q, stg_full_d;
    logic [CH-1:0]   stg_d_q, stg_d_d;
    logic [3*CH-1:0] stg_fmt_q, stg_fmt_d;
    logic [AW-1:0]   stg_sel_q, stg_sel_d;

    logic [CH-1:0]   act_d_q, act_d_d;
    logic [3*CH-1:0] act_fmt_q, act_fmt_d;
    logic [EW-1:0]   act_le_q, act_le_d;
    logic [EW-1:0]   act_te_q, act_te_d;
    logic [LW-1:0]   act_len_q, act_len_d;

    logic [LW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [CH-1:0]   q_q, q_d;
    logic            cs_q, cs_d;
    logic            underrun_q, underrun_d;
    logic            overrun_q, overrun_d;

    logic [EW-1:0]   sel_le, sel_te;
    logic [LW-1:0]   sel_len;
    logic [LW-1:0]   l_eff;
    logic            xfer, ready, load_ok, win;
    logic [CW-1:0]   cnt_w, le_w, te_w;

    assign l_eff   = (act_len_q < LW'(2)) ? LW'(2) : act_len_q;
    assign xfer    = en_i & (~run_q | (cnt_q == l_eff - LW'(1)));
    assign ready   = ~stg_full_q | xfer;
    assign load_ok = load_i & ready;

    // Snapshot source: the timing set named by the staged vector.
    always_comb begin
        sel_le  = '0;
        sel_te  = '0;
        sel_len = '0;
        for (int e = 0; e < NTS; e++) begin
            if (stg_sel_q == AW'(e)) begin
                sel_le  = ts_le_q[e];
                sel_te  = ts_te_q[e];
                sel_len = ts_len_q[e];
            end
        end
    end

    always_comb begin
        stg_full_d = stg_full_q;
        stg_d_d    = stg_d_q;
        stg_fmt_d  = stg_fmt_q;
        stg_sel_d  = stg_sel_q;
        act_d_d    = act_d_q;
        act_fmt_d  = act_fmt_q;
        act_le_d   = act_le_q;
        act_te_d   = act_te_q;
        act_len_d  = act_len_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        cs_d       = xfer;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;

        if (!en_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (xfer) begin
            run_d = 1'b1;
            cnt_d = '0;
            if (stg_full_q) begin
                act_d_d    = stg_d_q;
                act_fmt_d  = stg_fmt_q;
                act_le_d   = sel_le;
                act_te_d   = sel_te;
                act_len_d  = sel_len;
                stg_full_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + LW'(1);
        end

        // A load in the transfer clock refills the slot just vacated.
        if (load_ok) begin
            stg_full_d = 1'b1;
            stg_d_d    = d_i;
            stg_fmt_d  = fmt_i;
            stg_sel_d  = tset_sel_i;
        end

        if (clr_flags_i) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (xfer && !stg_full_q) underrun_d = 1'b1;
        if (load_i && !ready)    overrun_d  = 1'b1;
    end

    assign cnt_w = CW'(cnt_q);
    assign le_w  = CW'(act_le_q);
    assign te_w  = CW'(act_te_q);
    assign win   = (le_w <= cnt_w) && (cnt_w < te_w);

    always_comb begin
        q_d = '0;
        if (en_i && run_q) begin
            for (int i = 0; i < CH; i++) begin
                case (act_fmt_q[3*i +: 3])
                    FMT_NRZ:  q_d[i] = act_d_q[i];
                    FMT_DNRZ: q_d[i] = (cnt_w == le_w) ? act_d_q[i] : q_q[i];
                    FMT_RZ:   q_d[i] = win ? act_d_q[i] : 1'b0;
                    FMT_R1:   q_d[i] = win ? act_d_q[i] : 1'b1;
                    FMT_SBC:  q_d[i] = win ? act_d_q[i] : ~act_d_q[i];
                    default:  q_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NTS; e++) begin
                ts_le_q[e]  <= '0;
                ts_te_q[e]  <= '0;
                ts_len_q[e] <= '0;
            end
            stg_full_q <= 1'b0;
            stg_d_q    <= '0;
            stg_fmt_q  <= '0;
            stg_sel_q  <= '0;
            act_d_q    <= '0;
            act_fmt_q  <= '0;
            act_le_q   <= '0;
            act_te_q   <= '0;
            act_len_q  <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            q_q        <= '0;
            cs_q       <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            for (int e = 0; e < NTS; e++) begin
                if (tset_wr_i && tset_addr_i == AW'(e)) begin
                    ts_le_q[e]  <= tset_le_i;
                    ts_te_q[e]  <= tset_te_i;
                    ts_len_q[e] <= tset_len_i;
                end
            end
            stg_full_q <= stg_full_d;
            stg_d_q    <= stg_d_d;
            stg_fmt_q  <= stg_fmt_d;
            stg_sel_q  <= stg_sel_d;
            act_d_q    <= act_d_d;
            act_fmt_q  <= act_fmt_d;
            act_le_q   <= act_le_d;
            act_te_q   <= act_te_d;
            act_len_q  <= act_len_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            q_q        <= q_d;
            cs_q       <= cs_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign q_o           = q_q;
    assign ready_o       = ready;
    assign cycle_start_o = cs_q;
    assign underrun_o    = underrun_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_db_format_bank.sv
// Directed bench for db_format_bank: formats, timing sets, staging flags and async reset.
module tb_db_format_bank;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [7:0]  d;
    logic [23:0] fmt;
    logic [0:0]  tset_sel;
    logic        tset_wr;
    logic [0:0]  tset_addr;
    logic [6:0]  tset_le;
    logic [6:0]  tset_te;
    logic [7:0]  tset_len;
    logic        clr_flags;
    logic [7:0]  q;
    logic        ready;
    logic        cycle_start;
    logic        underrun;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [23:0] RZ_ALL  = {8{3'b010}};
    localparam logic [23:0] NRZ_ALL = 24'h0;
    localparam logic [23:0] FMT_MIX = {3'b111, 3'b110, 3'b101, 3'b100,
                                       3'b011, 3'b010, 3'b001, 3'b000};

    logic [7:0] exp2 [16];
    logic [7:0] exp_q;

    db_format_bank dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .load_i        (load),
        .d_i           (d),
        .fmt_i         (fmt),
        .tset_sel_i    (tset_sel),
        .tset_wr_i     (tset_wr),
        .tset_addr_i   (tset_addr),
        .tset_le_i     (tset_le),
        .tset_te_i     (tset_te),
        .tset_len_i    (tset_len),
        .clr_flags_i   (clr_flags),
        .q_o           (q),
        .ready_o       (ready),
        .cycle_start_o (cycle_start),
        .underrun_o    (underrun),
        .overrun_o     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        d         = '0;
        fmt       = '0;
        tset_sel  = '0;
        tset_wr   = 1'b0;
        tset_addr = '0;
        tset_le   = '0;
        tset_te   = '0;
        tset_len  = '0;
        clr_flags = 1'b0;
        exp2 = '{8'h09, 8'h09, 8'h1F, 8'h1F, 8'h1F, 8'h0B, 8'h0B, 8'h0B,
                 8'h1A, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h18};

        // Reset values
        #12;
        chk("rst_q", q, 0);
        chk("rst_ready", ready, 1);
        chk("rst_cs", cycle_start, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Basic RZ on all channels, set0 = {LE=2, TE=5, LEN=8}
        tset_wr = 1'b1; tset_addr = 1'b0; tset_le = 7'd2; tset_te = 7'd5; tset_len = 8'd8;
        tick();
        tset_wr = 1'b0;
        load = 1'b1; d = 8'hFF; fmt = RZ_ALL; tset_sel = 1'b0;
        tick();
        load = 1'b0;
        chk("p1_ready_full", ready, 0);
        chk("p1_q_idle", q, 0);
        en = 1'b1;
        #1;
        chk("p1_ready_xfer", ready, 1);
        for (int n = 1; n <= 17; n++) begin
            tick();
            exp_q = (n >= 2 && ((n - 2) % 8) >= 2 && ((n - 2) % 8) <= 4) ? 8'hFF : 8'h00;
            chk($sformatf("p1_q_e%0d", n), q, exp_q);
            chk($sformatf("p1_cs_e%0d", n), cycle_start, (n % 8) == 1);
            chk($sformatf("p1_under_e%0d", n), underrun, n >= 9);
        end
        en = 1'b0;
        tick();
        chk("p1_en_off_q", q, 0);
        chk("p1_en_off_cs", cycle_start, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("p1_clr_under", underrun, 0);

        // Per-channel formats, d=1 then d=0, second load alongside the first xfer
        load = 1'b1; d = 8'hFF; fmt = FMT_MIX; tset_sel = 1'b0;
        tick();
        d = 8'h00; en = 1'b1;
        tick();
        load = 1'b0;
        chk("p2_cs_e1", cycle_start, 1);
        chk("p2_q_e1", q, 0);
        chk("p2_over_e1", overrun, 0);
        for (int k = 2; k <= 17; k++) begin
            tick();
            chk($sformatf("p2_q_e%0d", k), q, exp2[k-2]);
        end
        chk("p2_under_end", underrun, 1);
        chk("p2_over_end", overrun, 0);
        en = 1'b0;
        tick();

        // Timing sets: set1 LEN=4, rewritten to LEN=1 while it is running
        clr_flags = 1'b1;
        tset_wr = 1'b1; tset_addr = 1'b1; tset_le = 7'd1; tset_te = 7'd3; tset_len = 8'd4;
        tick();
        clr_flags = 1'b0; tset_wr = 1'b0;
        load = 1'b1; d = 8'hFF; fmt = NRZ_ALL; tset_sel = 1'b0;
        tick();
        tset_sel = 1'b1; en = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            tick();
            chk($sformatf("p3_cs_e%0d", n), cycle_start,
                (n == 1 || n == 9 || n == 13 || n == 21 || n == 23 || n == 25));
            chk($sformatf("p3_under_e%0d", n), underrun, n >= 23);
            chk($sformatf("p3_over_e%0d", n), overrun, 0);
            if (n == 1)  load = 1'b0;
            if (n == 9)  begin load = 1'b1; tset_sel = 1'b0; end
            if (n == 10) begin
                load = 1'b0;
                tset_wr = 1'b1; tset_addr = 1'b1; tset_le = 7'd1; tset_te = 7'd3; tset_len = 8'd1;
            end
            if (n == 11) tset_wr = 1'b0;
            if (n == 13) begin load = 1'b1; tset_sel = 1'b1; end
            if (n == 14) load = 1'b0;
        end
        en = 1'b0;
        tick();

        // Overrun: second load ignored; clear loses to a same-clock set
        clr_flags = 1'b1;
        load = 1'b1; d = 8'h5A; fmt = NRZ_ALL; tset_sel = 1'b0;
        tick();
        clr_flags = 1'b0;
        chk("p4_ready_full", ready, 0);
        chk("p4_over_clr", overrun, 0);
        chk("p4_under_clr", underrun, 0);
        d = 8'hA5;
        tick();
        chk("p4_over_set", overrun, 1);
        chk("p4_ready_still", ready, 0);
        d = 8'hC3; clr_flags = 1'b1;
        tick();
        chk("p4_over_clr_vs_set", overrun, 1);
        load = 1'b0;
        tick();
        clr_flags = 1'b0;
        chk("p4_over_cleared", overrun, 0);

        // Load in the same clock as a running xfer with staging full, then async reset
        en = 1'b1;
        for (int g = 1; g <= 20; g++) begin
            tick();
            if (g == 1) chk("p5_cs_g1", cycle_start, 1);
            if (g == 2) begin
                chk("p4_first_vector_kept", q, 8'h5A);
                load = 1'b1; d = 8'h11;
            end
            if (g == 3) load = 1'b0;
            if (g == 8) begin
                load = 1'b1; d = 8'h22;
                #1;
                chk("p5_ready_at_xfer", ready, 1);
            end
            if (g == 9) begin
                load = 1'b0;
                chk("p5_cs_g9", cycle_start, 1);
                chk("p5_over_g9", overrun, 0);
                chk("p5_under_g9", underrun, 0);
            end
            if (g == 10) chk("p5_q_first", q, 8'h11);
            if (g == 17) begin
                chk("p5_cs_g17", cycle_start, 1);
                chk("p5_under_g17", underrun, 0);
                chk("p5_over_g17", overrun, 0);
                load = 1'b1; d = 8'h33;
            end
            if (g == 18) begin
                chk("p5_q_second", q, 8'h22);
                d = 8'h44;
            end
            if (g == 19) begin
                load = 1'b0;
                chk("p6_over_pre", overrun, 1);
            end
            if (g == 20) chk("p6_q_pre", q, 8'h22);
        end

        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_rst_q", q, 0);
        chk("p6_rst_ready", ready, 1);
        chk("p6_rst_over", overrun, 0);
        chk("p6_rst_under", underrun, 0);
        chk("p6_rst_cs", cycle_start, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("p6_h1_cs", cycle_start, 1);
        chk("p6_h1_under", underrun, 1);
        tick();
        chk("p6_h2_q", q, 0);
        chk("p6_h2_cs", cycle_start, 0);
        tick();
        chk("p6_h3_cs", cycle_start, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
